// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store sequencer.
package lsu_pkg;

  localparam int LSU_ADDR_W = 8;
  localparam int LSU_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Request-op flags captured at accept time.
  typedef struct packed {
    logic write;  // 1 = store, 0 = load
    logic wide;   // 1 = two-byte access
    logic sext;   // narrow load sign-extends the top bit of the low byte
  } lsu_op_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a byte-wide data memory.
// Computes base+offset (wrapping), strobes one or two consecutive lines
// (little-endian), and returns the assembled result over a valid/ready pair.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_base,
  input  logic [ADDR_W-1:0]     req_offset,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]     lineNumber,
  output logic [DATA_W-1:0]     memIn,
  output logic                  memRead,
  output logic                  memWrite,
  input  logic [DATA_W-1:0]     memOut
);

  lsu_state_e               state_q, state_d;
  lsu_op_t                  op_q, op_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_hi_q, wdata_hi_d;
  logic [2*DATA_W-1:0]      rdata_q, rdata_d;
  logic [ADDR_W-1:0]        line_q, line_d;
  logic [DATA_W-1:0]        mem_in_q, mem_in_d;
  logic [ADDR_W-1:0]        ea;

  assign ea = req_base + req_offset;

  // Next-state, capture and result-assembly logic.
  // lineNumber/memIn are loaded one edge early (at accept, and at the end of
  // BYTE0 for wide ops) so they are stable for the whole strobe cycle.
  // A narrow load builds its upper byte at the end of BYTE0 so the result
  // register is complete when RESP is entered.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_hi_d = wdata_hi_q;
    rdata_d    = rdata_q;
    line_d     = line_q;
    mem_in_d   = mem_in_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d       = '{write: req_write, wide: req_wide, sext: req_signed};
          addr_d     = ea;
          wdata_hi_d = req_wdata[2*DATA_W-1:DATA_W];
          rdata_d    = '0;
          line_d     = ea;
          mem_in_d   = req_wdata[DATA_W-1:0];
          state_d    = BYTE0;
        end
      end
      BYTE0: begin
        if (!op_q.write) begin
          rdata_d[DATA_W-1:0] = memOut;
          if (!op_q.wide) begin
            rdata_d[2*DATA_W-1:DATA_W] = op_q.sext ? {DATA_W{memOut[DATA_W-1]}} : '0;
          end
        end
        if (op_q.wide) begin
          line_d   = addr_q + ADDR_W'(1);
          mem_in_d = wdata_hi_q;
          state_d  = BYTE1;
        end else begin
          state_d  = RESP;
        end
      end
      BYTE1: begin
        if (!op_q.write) begin
          rdata_d[2*DATA_W-1:DATA_W] = memOut;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      rdata_q    <= '0;
      line_q     <= '0;
      mem_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_hi_q <= wdata_hi_d;
      rdata_q    <= rdata_d;
      line_q     <= line_d;
      mem_in_q   <= mem_in_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign lineNumber = line_q;
  assign memIn      = mem_in_q;
  assign memRead    = ((state_q == BYTE0) || (state_q == BYTE1)) && !op_q.write;
  assign memWrite   = ((state_q == BYTE0) || (state_q == BYTE1)) &&  op_q.write;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_wide, req_signed;
  logic [7:0]  req_base, req_offset;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic [7:0]  lineNumber, memIn, memOut;
  logic        memRead, memWrite;

  load_store_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wide(req_wide), .req_signed(req_signed), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .lineNumber(lineNumber), .memIn(memIn), .memRead(memRead),
    .memWrite(memWrite), .memOut(memOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Data memory (environment) and reference copy used by the model.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  assign memOut = mem[lineNumber];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    forever begin
      @(posedge clk);
      if (memWrite) mem[lineNumber] <= memIn;
    end
  end

  // Scoreboards.
  typedef struct { logic [15:0] rdata; int acc; int lat; } rsp_t;
  typedef struct { logic [7:0] line; logic wr; logic [7:0] data; } stb_t;
  rsp_t exp_q[$];
  stb_t st_q[$];
  logic strobe_en = 1'b1;

  // Reference model: computes effects from the architectural rules.
  task automatic model_push(input logic w, input logic wd, input logic sg,
                            input logic [7:0] b, input logic [7:0] o,
                            input logic [15:0] d, input int acc);
    logic [7:0]  a0, a1;
    logic [15:0] r;
    a0 = 8'((int'(b) + int'(o)) % 256);
    a1 = 8'((int'(a0) + 1) % 256);
    r  = 16'h0;
    if (w) begin
      ref_mem[a0] = d[7:0];
      if (wd) ref_mem[a1] = d[15:8];
    end else if (wd) begin
      r = {ref_mem[a1], ref_mem[a0]};
    end else begin
      r = {(sg && ref_mem[a0][7]) ? 8'hFF : 8'h00, ref_mem[a0]};
    end
    st_q.push_back('{line: a0, wr: w, data: d[7:0]});
    if (wd) st_q.push_back('{line: a1, wr: w, data: d[15:8]});
    exp_q.push_back('{rdata: r, acc: acc, lat: wd ? 3 : 2});
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    if (!reset && strobe_en && (memRead || memWrite)) begin
      stb_t s;
      check("strobe_exclusive", {memRead, memWrite}, {~memWrite, memWrite});
      if (st_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_strobe: got line 0x%0h rd %0b wr %0b expected none", lineNumber, memRead, memWrite);
      end else begin
        s = st_q.pop_front();
        check("strobe_line", lineNumber, s.line);
        check("strobe_dir", memWrite, s.wr);
        if (s.wr) check("strobe_memIn", memIn, s.data);
      end
    end
  end

  // Response monitor.
  logic        prev_valid = 1'b0;
  logic [15:0] held;
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid && !prev_valid) begin
        held = rsp_rdata;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp: got 0x%0h expected no response", rsp_rdata);
        end else begin
          check("rsp_latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end
      end else if (rsp_valid) begin
        check("rsp_stable", rsp_rdata, held);
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_req_ready_low", req_ready, 0);
      end
      prev_valid = rsp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // rsp_ready driver: 0 random, 1 high, 2 low.
  int rdy_mode = 1;
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic issue(input logic w, input logic wd, input logic sg,
                       input logic [7:0] b, input logic [7:0] o,
                       input logic [15:0] d, output int acc);
    req_write = w; req_wide = wd; req_signed = sg;
    req_base = b; req_offset = o; req_wdata = d; req_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        model_push(w, wd, sg, b, o, d, acc);
        break;
      end
    end
    if (acc < 0) fail_now("accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && st_q.size() == 0 && req_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, prev_acc;
    logic prev_wd, wd, found;
    logic [7:0] hi_orig, lo_new;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
    req_signed = 1'b0; req_base = '0; req_offset = '0; req_wdata = '0;
    #1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_lineNumber", lineNumber, 0);
    check("reset_memIn", memIn, 0);
    check("reset_memRead", memRead, 0);
    check("reset_memWrite", memWrite, 0);
    @(posedge clk); #1;

    // Directed cases.
    issue(1, 0, 0, 8'h10, 8'h05, 16'h00AB, acc); req_valid = 0; drain();
    issue(0, 0, 1, 8'h10, 8'h05, 16'h0000, acc); req_valid = 0; drain();
    issue(0, 0, 0, 8'h10, 8'h05, 16'h0000, acc); req_valid = 0; drain();
    issue(1, 1, 0, 8'hFF, 8'h00, 16'h1234, acc); req_valid = 0; drain();
    issue(0, 1, 0, 8'hFF, 8'h00, 16'h0000, acc); req_valid = 0; drain();
    issue(0, 0, 0, 8'h03, 8'hFE, 16'h0000, acc); req_valid = 0;
    check("neg_offset_line", lineNumber, 8'h01);
    drain();

    // Response stall with req_valid pulsing.
    rdy_mode = 2;
    @(posedge clk); #2;
    issue(0, 0, 1, 8'h10, 8'h05, 16'h0000, acc); req_valid = 0;
    found = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1; break; end
    end
    if (!found) fail_now("stall_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = i[0] ? 1'b0 : 1'b1;
      req_base = 8'($urandom); req_write = 1'b1;
      @(negedge clk);
      check("stall_req_ready", req_ready, 0);
      check("stall_rsp_valid", rsp_valid, 1);
    end
    @(posedge clk); #1;
    req_valid = 0;
    rdy_mode = 1;
    drain();

    // Throughput with rsp_ready tied high.
    prev_acc = -1; prev_wd = 0;
    for (int i = 0; i < 6; i++) begin
      wd = (i == 1 || i == 3 || i == 4);
      issue(logic'($urandom_range(0, 1)), wd, logic'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), 16'($urandom), acc);
      if (prev_acc >= 0) check("throughput_gap", acc - prev_acc, prev_wd ? 4 : 3);
      prev_acc = acc; prev_wd = wd;
    end
    req_valid = 0;
    drain();

    // Randomized traffic with random back-pressure; addresses kept in a
    // small window so loads revisit stored lines.
    rdy_mode = 0;
    for (int i = 0; i < 80; i++) begin
      issue(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), 8'($urandom_range(0, 15)) + 8'hF8,
            8'($urandom_range(0, 15)) - 8'd8, 16'($urandom), acc);
      req_valid = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    drain();

    // Reset during BYTE1 of a wide store.
    strobe_en = 0;
    hi_orig = mem[8'h41];
    lo_new  = ~mem[8'h40];
    req_write = 1; req_wide = 1; req_signed = 0; req_base = 8'h40;
    req_offset = 8'h00; req_wdata = {~hi_orig, lo_new}; req_valid = 1;
    @(negedge clk);
    check("rst_test_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
    found = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (memWrite && lineNumber == 8'h41) begin found = 1; break; end
    end
    check("rst_test_reach_byte1", found, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_memWrite", memWrite, 0);
    check("rst_mid_memRead", memRead, 0);
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_low_byte_written", mem[8'h40], lo_new);
    check("rst_high_byte_kept", mem[8'h41], hi_orig);
    ref_mem[8'h40] = lo_new;
    strobe_en = 1;

    // A clean op after the interrupted one.
    @(posedge clk); #1;
    issue(0, 1, 0, 8'h40, 8'h00, 16'h0000, acc); req_valid = 0;
    drain();

    check("rsp_queue_empty", exp_q.size(), 0);
    check("strobe_queue_empty", st_q.size(), 0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("memory_image_mismatches", bad, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
